spi_reg_bank: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 19 +
 rtl/spi_edge_sync.sv | 33 +++
 rtl/spi_reg_bank.sv | 165 ++++++++++++++++
 tb/tb_spi_reg_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and helpers for the SPI register bank
package spi_reg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_COMMIT,
      ST_WAIT
   } state_t;

   localparam logic [3:0] CMD_WRITE_DEF = 4'b0001;
   localparam logic [3:0] CMD_READ_DEF  = 4'b0010;

   function automatic int frame_width(input int cmd_w, input int addr_w, input int data_w);
      return cmd_w + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - 2-FF synchroniser with rise/fall pulse detection
module spi_edge_sync #(
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic clock_5meg_i,
   input  logic rst_low_i,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clock_5meg_i) begin
      if (!rst_low_i) begin
         meta <= IDLE_LEVEL;
         sync <= IDLE_LEVEL;
         prev <= IDLE_LEVEL;
      end else begin
         meta <= pin;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~prev;
   assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - oversampled SPI slave with writable, read-back register file
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int                   CMD_WIDTH  = 4,
   parameter int                   ADDR_WIDTH = 4,
   parameter int                   DATA_WIDTH = 8,
   parameter int                   NUM_REGS   = 9,
   parameter logic [CMD_WIDTH-1:0] CMD_WRITE  = CMD_WIDTH'(CMD_WRITE_DEF),
   parameter logic [CMD_WIDTH-1:0] CMD_READ   = CMD_WIDTH'(CMD_READ_DEF)
) (
   input  logic                           clock_5meg_i,
   input  logic                           rst_low_i,
   input  logic                           spi_sclk_i,
   input  logic                           spi_ss_i,
   input  logic                           spi_mosi_i,
   output logic                           spi_miso_o,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   output logic                           wr_strobe_o,
   output logic [ADDR_WIDTH-1:0]          wr_addr_o,
   output logic                           err_o
);

   localparam int FRAME    = frame_width(CMD_WIDTH, ADDR_WIDTH, DATA_WIDTH);
   localparam int HDR_BITS = CMD_WIDTH + ADDR_WIDTH;
   localparam int CNT_W    = $clog2(FRAME + 1);
   localparam logic [CNT_W-1:0]    HDR_LAST   = CNT_W'(HDR_BITS - 1);
   localparam logic [CNT_W-1:0]    FRAME_LAST = CNT_W'(FRAME - 1);
   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

   logic sclk_rise, sclk_fall, ss_lvl, ss_rise, ss_fall, mosi_lvl;
   logic unused_sclk_lvl, unused_mosi_rise, unused_mosi_fall;

   spi_edge_sync #(.IDLE_LEVEL(1'b1)) u_sync_sclk (
      .clock_5meg_i(clock_5meg_i), .rst_low_i(rst_low_i), .pin(spi_sclk_i),
      .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   spi_edge_sync #(.IDLE_LEVEL(1'b1)) u_sync_ss (
      .clock_5meg_i(clock_5meg_i), .rst_low_i(rst_low_i), .pin(spi_ss_i),
      .level(ss_lvl), .rise(ss_rise), .fall(ss_fall));

   spi_edge_sync #(.IDLE_LEVEL(1'b1)) u_sync_mosi (
      .clock_5meg_i(clock_5meg_i), .rst_low_i(rst_low_i), .pin(spi_mosi_i),
      .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [FRAME-1:0]        rx_sh;
   logic [FRAME-1:0]        rx_next;
   logic [CMD_WIDTH-1:0]    cmd_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [CMD_WIDTH-1:0]    hdr_cmd;
   logic [ADDR_WIDTH-1:0]   hdr_addr;
   logic [DATA_WIDTH-1:0]   tx_sh;
   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
   logic                    miso_q;
   logic                    wr_strobe_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic                    err_q;
   logic                    armed;
   logic [1:0]              settle;
   logic                    hdr_addr_ok;
   logic                    addr_ok;

   assign rx_next     = {rx_sh[FRAME-2:0], mosi_lvl};
   assign hdr_cmd     = rx_next[HDR_BITS-1 -: CMD_WIDTH];
   assign hdr_addr    = rx_next[ADDR_WIDTH-1:0];
   assign hdr_addr_ok = {1'b0, hdr_addr} < NUM_REGS_W;
   assign addr_ok     = {1'b0, addr_q} < NUM_REGS_W;

   // armed only after ss is seen high once the synchronisers hold real pin values,
   // so a reset in the middle of a frame cannot pick up the tail of that frame
   always_ff @(posedge clock_5meg_i) begin
      if (!rst_low_i) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         rx_sh       <= '0;
         cmd_q       <= '0;
         addr_q      <= '0;
         tx_sh       <= '1;
         miso_q      <= 1'b1;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         err_q       <= 1'b0;
         armed       <= 1'b0;
         settle      <= '0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else begin
         settle      <= {settle[0], 1'b1};
         wr_strobe_q <= 1'b0;
         if (settle[1] && ss_lvl) armed <= 1'b1;
         case (state)
            ST_IDLE: begin
               miso_q <= 1'b1;
               if (armed && ss_fall) begin
                  cnt   <= '0;
                  state <= ST_HDR;
               end
            end
            ST_HDR: begin
               miso_q <= 1'b1;
               if (ss_rise) begin
                  state <= ST_IDLE;
               end else if (sclk_rise) begin
                  rx_sh <= rx_next;
                  cnt   <= cnt + 1'b1;
                  if (cnt == HDR_LAST) begin
                     cmd_q  <= hdr_cmd;
                     addr_q <= hdr_addr;
                     tx_sh  <= (hdr_cmd == CMD_READ && hdr_addr_ok) ? regs[hdr_addr] : '1;
                     state  <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               // a final rise coinciding with deselect still completes the frame
               if (sclk_rise && cnt == FRAME_LAST) begin
                  rx_sh  <= rx_next;
                  cnt    <= cnt + 1'b1;
                  miso_q <= 1'b1;
                  state  <= ST_COMMIT;
               end else if (ss_rise) begin
                  miso_q <= 1'b1;
                  state  <= ST_IDLE;
               end else if (sclk_rise) begin
                  rx_sh <= rx_next;
                  cnt   <= cnt + 1'b1;
               end else if (sclk_fall) begin
                  miso_q <= tx_sh[DATA_WIDTH-1];
                  tx_sh  <= {tx_sh[DATA_WIDTH-2:0], 1'b1};
               end
            end
            ST_COMMIT: begin
               miso_q <= 1'b1;
               if (cmd_q == CMD_WRITE && addr_ok) begin
                  regs[addr_q] <= rx_sh[DATA_WIDTH-1:0];
                  wr_strobe_q  <= 1'b1;
                  wr_addr_q    <= addr_q;
               end else if (!(cmd_q == CMD_READ && addr_ok)) begin
                  err_q <= 1'b1;
               end
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               miso_q <= 1'b1;
               if (ss_lvl) state <= ST_IDLE;
            end
            default: begin
               miso_q <= 1'b1;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
   end

   assign spi_miso_o  = miso_q;
   assign wr_strobe_o = wr_strobe_q;
   assign wr_addr_o   = wr_addr_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - self-checking bench for spi_reg_bank
module tb_spi_reg_bank;

   localparam int NREG = 9;
   localparam int DW   = 8;
   localparam int HALF = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sclk = 1'b1;
   logic              ss = 1'b1;
   logic              mosi = 1'b1;
   logic              miso;
   logic [NREG*DW-1:0] regs;
   logic              strobe;
   logic [3:0]        waddr;
   logic              err;

   always #5 clk = ~clk;

   spi_reg_bank dut (
      .clock_5meg_i(clk),
      .rst_low_i(rst_n),
      .spi_sclk_i(sclk),
      .spi_ss_i(ss),
      .spi_mosi_i(mosi),
      .spi_miso_o(miso),
      .regs_o(regs),
      .wr_strobe_o(strobe),
      .wr_addr_o(waddr),
      .err_o(err)
   );

   int errors = 0;
   int checks = 0;
   int strobe_cycles = 0;

   logic [7:0] m_regs [NREG];
   logic       m_err;
   logic [3:0] m_addr;
   int         m_strobes;

   always @(negedge clk) if (strobe === 1'b1) strobe_cycles++;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREG*DW-1:0] model_vec();
      logic [NREG*DW-1:0] v;
      for (int k = 0; k < NREG; k++) v[k*DW +: DW] = m_regs[k];
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_clear();
      for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
      m_err  = 1'b0;
      m_addr = 4'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      model_clear();
      tick(4);
   endtask

   task automatic spi_bit(input logic b, input bit ss_on_rise, output logic mi);
      sclk = 1'b0;
      mosi = b;
      tick(HALF);
      mi   = miso;
      sclk = 1'b1;
      if (ss_on_rise) ss = 1'b1;
      tick(HALF);
   endtask

   task automatic check_state(input string tag);
      check({tag, " regs"}, regs, model_vec());
      check({tag, " err"}, err, m_err);
      check({tag, " strobes"}, strobe_cycles, m_strobes);
      check({tag, " wr_addr"}, waddr, m_addr);
      check({tag, " miso_idle"}, miso, 1'b1);
   endtask

   task automatic run_frame(input string tag, input logic [31:0] bits, input int n, input bit ss_last);
      logic [31:0] mi;
      logic        m;
      logic [15:0] f;
      logic [3:0]  c;
      logic [3:0]  a;
      logic [7:0]  exp_rd;
      bool_dummy: begin end
      mi = '0;
      ss = 1'b0;
      tick(HALF);
      for (int i = n - 1; i >= 0; i--) begin
         spi_bit(bits[i], ss_last && (i == 0), m);
         mi = {mi[30:0], m};
      end
      ss   = 1'b1;
      mosi = 1'b1;
      tick(10);
      check({tag, " miso_hdr"}, mi[n-1 -: 8], 8'hFF);
      if (n >= 16) begin
         f = 16'(bits >> (n - 16));
         c = f[15:12];
         a = f[11:8];
         exp_rd = 8'hFF;
         if (c == 4'h2 && a < NREG) exp_rd = m_regs[a];
         if (c == 4'h1 && a < NREG) begin
            m_regs[a] = f[7:0];
            m_strobes++;
            m_addr = a;
         end else if (!(c == 4'h2 && a < NREG)) begin
            m_err = 1'b1;
         end
         check({tag, " miso_data"}, mi[n-9 -: 8], exp_rd);
      end
      check_state(tag);
   endtask

   initial begin
      logic        m;
      logic [3:0]  rc;
      logic [3:0]  ra;
      logic [7:0]  rd;
      int          rn;
      logic [15:0] rf;
      m_strobes = 0;
      model_clear();

      tick(4);
      check_state("reset");
      rst_n = 1'b1;
      tick(4);

      run_frame("write3", 32'h13A5, 16, 1'b0);
      run_frame("write7", 32'h175C, 16, 1'b0);
      run_frame("read7",  32'h2700, 16, 1'b0);
      run_frame("abort",  32'h12FF >> 6, 10, 1'b0);
      run_frame("write2", 32'h1211, 16, 1'b0);
      run_frame("bad_addr", 32'h1C33, 16, 1'b0);

      do_reset();
      check_state("reset2");
      run_frame("bad_cmd", 32'hF3AA, 16, 1'b0);

      do_reset();
      run_frame("read9", 32'h2900, 16, 1'b0);

      do_reset();
      run_frame("over", {12'h0, 16'h1001, 4'hA}, 20, 1'b0);
      run_frame("b2b", 32'h1102, 16, 1'b0);
      run_frame("ss_last", 32'h1477, 16, 1'b1);

      // reset while a frame is in progress, then let the master finish it
      ss = 1'b0;
      tick(HALF);
      for (int i = 15; i >= 10; i--) spi_bit(rf_const(i), 1'b0, m);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      model_clear();
      check("midrst miso", miso, 1'b1);
      for (int i = 9; i >= 0; i--) spi_bit(rf_const(i), 1'b0, m);
      ss = 1'b1;
      tick(10);
      check_state("midrst");
      run_frame("post_rst", 32'h1355, 16, 1'b0);

      for (int t = 0; t < 24; t++) begin
         case ($urandom_range(0, 4))
            0, 1:    rc = 4'h1;
            2, 3:    rc = 4'h2;
            default: rc = 4'($urandom);
         endcase
         ra = 4'($urandom_range(0, 11));
         rd = 8'($urandom);
         rf = {rc, ra, rd};
         rn = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 15) : 16;
         run_frame("rand", 32'(rf) >> (16 - rn), rn, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   function automatic logic rf_const(input int i);
      logic [15:0] v;
      v = 16'h1388;
      return v[i];
   endfunction

endmodule
